// File: rtl/r16_pipe_elastic.sv
// Elastic DEPTH-stage register pipe carrying {A0, Ac, N, D} between R16 reduction sub-blocks.
// A combinational ready chain lets every stage shift when the stage ahead is empty or moving.

module r16_pipe_stage #(
   parameter int           W   = 1,
   parameter logic [W-1:0] RST = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         adv,
   input  logic         v_in,
   input  logic [W-1:0] d_in,
   output logic         v_nxt,
   output logic         v,
   output logic [W-1:0] d
);
   assign v_nxt = flush ? 1'b0 : (adv ? v_in : v);

   // Data only moves with a valid beat, so a held output never sees bubble data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= 1'b0;
         d <= RST;
      end else begin
         v <= v_nxt;
         if (!flush && adv && v_in) d <= d_in;
      end
   end
endmodule

module r16_pipe_elastic #(
   parameter int                 P_WIDTH = 64,
   parameter int                 DEPTH   = 4,
   parameter logic [P_WIDTH-1:0] P_ZERO  = {P_WIDTH{1'b0}},
   localparam int                CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [P_WIDTH-1:0] A0_in,
   input  logic               Ac_in,
   input  logic [P_WIDTH-1:0] N_in,
   input  logic [P_WIDTH-1:0] D_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P_WIDTH-1:0] A0_out,
   output logic               Ac_out,
   output logic [P_WIDTH-1:0] N_out,
   output logic [P_WIDTH-1:0] D_out,
   output logic [CNT_W-1:0]   occupancy
);
   localparam int            BW  = 3 * P_WIDTH + 1;
   localparam logic [BW-1:0] RST = {P_ZERO, 1'b0, P_ZERO, P_ZERO};

   logic [DEPTH:0]             rdy;
   logic [DEPTH-1:0]           v, v_nxt, v_src;
   logic [DEPTH-1:0][BW-1:0]   d, d_src;
   logic [CNT_W-1:0]           cnt_nxt;

   assign rdy[DEPTH] = out_ready;
   assign in_ready   = rdy[0] & ~flush;

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      assign rdy[s] = ~v[s] | rdy[s+1];
      if (s == 0) begin : g_head
         assign v_src[s] = in_valid & in_ready;
         assign d_src[s] = {A0_in, Ac_in, N_in, D_in};
      end else begin : g_body
         assign v_src[s] = v[s-1];
         assign d_src[s] = d[s-1];
      end
      r16_pipe_stage #(.W(BW), .RST(RST)) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .flush (flush),
         .adv   (rdy[s]),
         .v_in  (v_src[s]),
         .d_in  (d_src[s]),
         .v_nxt (v_nxt[s]),
         .v     (v[s]),
         .d     (d[s])
      );
   end

   always_comb begin
      cnt_nxt = '0;
      for (int s = 0; s < DEPTH; s++) cnt_nxt = cnt_nxt + CNT_W'(v_nxt[s]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) occupancy <= '0;
      else        occupancy <= cnt_nxt;
   end

   assign out_valid                        = v[DEPTH-1];
   assign {A0_out, Ac_out, N_out, D_out}   = d[DEPTH-1];
endmodule
